// File: rtl/onehot_ring_ctr.sv
// onehot_ring_ctr: one-hot ring sequencer with N positions.
// A single active bit steps up or down one position per advance request.
// The ends either wrap around or saturate. A parallel load moves the bit
// to any position, and status flags report wraps and rejected loads.
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-high reset (position returns to START)
//   adv       advance request
//   dir       0 = step up, 1 = step down
//   load      parallel load request (has priority over adv)
//   load_idx  position to load
//   Q         registered one-hot position
//   idx       registered binary position, always consistent with Q
//   wrap      one-cycle pulse: the last update crossed an end
//   at_end    combinational: at the end in the current direction
//   load_err  one-cycle pulse: the last load index was out of range
module onehot_ring_ctr #(
  parameter int N     = 8,
  parameter int START = 0,
  parameter bit WRAP  = 1'b1,
  localparam int IW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          adv,
  input  logic          dir,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  output logic [N-1:0]  Q,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          at_end,
  output logic          load_err
);

  if (N < 2 || N > 32) begin : g_bad_n
    $fatal(1, "onehot_ring_ctr: N=%0d outside 2..32", N);
  end
  if (START < 0 || START >= N) begin : g_bad_start
    $fatal(1, "onehot_ring_ctr: START=%0d outside 0..N-1", START);
  end

  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] FIRST = '0;
  localparam logic [IW-1:0] ONE   = IW'(1);
  localparam logic [IW-1:0] RST_I = IW'(START);
  localparam logic [IW:0]   NW    = (IW+1)'(N);
  localparam logic [N-1:0]  RST_Q = {{(N-1){1'b0}}, 1'b1} << START;

  logic [IW-1:0] idx_nxt;
  logic [N-1:0]  q_nxt;
  logic          wrap_nxt;
  logic          err_nxt;

  // Next position. Load beats advance; a rejected load still blocks adv.
  always_comb begin
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if ({1'b0, load_idx} < NW) idx_nxt = load_idx;
      else                       err_nxt = 1'b1;
    end else if (adv) begin
      if (!dir) begin
        if (idx != LAST)  idx_nxt = idx + ONE;
        else if (WRAP) begin
          idx_nxt  = FIRST;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (idx != FIRST) idx_nxt = idx - ONE;
        else if (WRAP) begin
          idx_nxt  = LAST;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Q is decoded from the next index, so both registers always load from
  // the same source and can never disagree.
  for (genvar k = 0; k < N; k++) begin : g_dec
    assign q_nxt[k] = (idx_nxt == IW'(k));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx      <= RST_I;
      Q        <= RST_Q;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      Q        <= q_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

  assign at_end = dir ? (idx == FIRST) : (idx == LAST);

endmodule
